// File: rtl/lc4_exec_seq.sv
// LC4 execute sequencer: fetches operands from an 8-entry register file, hands them
// to an external combinational ALU, then commits writeback, NZP and next PC (IDLE/EXEC/WB).
module lc4_exec_seq #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_insn_valid,
    output logic                 o_insn_ready,
    input  logic [15:0]          i_insn,
    input  logic [15:0]          i_pc,
    output logic [15:0]          o_alu_insn,
    output logic [15:0]          o_alu_pc,
    output logic [WORD_SIZE-1:0] o_alu_r1data,
    output logic [WORD_SIZE-1:0] o_alu_r2data,
    input  logic [WORD_SIZE-1:0] i_alu_result,
    output logic                 o_done,
    output logic                 o_wb_en,
    output logic [2:0]           o_wb_reg,
    output logic [WORD_SIZE-1:0] o_wb_data,
    output logic [15:0]          o_next_pc,
    output logic [2:0]           o_nzp,
    input  logic [2:0]           i_dbg_reg,
    output logic [WORD_SIZE-1:0] o_dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] rf_q [8];
    logic [2:0]           nzp_q, nzp_d;
    logic [15:0]          insn_q, pc_q;
    logic [WORD_SIZE-1:0] r1_q, r2_q, result_q;

    logic                 accept, in_wb;
    logic                 wb_en, is_cmp;
    logic [2:0]           wb_reg;
    logic [WORD_SIZE-1:0] wb_data;
    logic [15:0]          next_pc, pc_plus1;
    logic [3:0]           opcode;

    function automatic logic [2:0] nzp_of(input logic [WORD_SIZE-1:0] v);
        if (v[WORD_SIZE-1])
            return 3'b100;
        else if (v == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    assign accept   = (state_q == IDLE) && i_insn_valid;
    assign in_wb    = (state_q == WB);
    assign opcode   = insn_q[15:12];
    assign pc_plus1 = pc_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wb_en   = 1'b0;
        wb_reg  = insn_q[11:9];
        wb_data = result_q;
        next_pc = pc_plus1;
        is_cmp  = 1'b0;
        nzp_d   = nzp_q;

        case (state_q)
            IDLE:    if (i_insn_valid) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (opcode)
            4'b0001, 4'b0101, 4'b1001, 4'b1010, 4'b1101: wb_en = 1'b1;
            4'b0100, 4'b1111: begin
                // Subroutine linkage always lands in R7 and jumps to the ALU target.
                wb_en   = 1'b1;
                wb_reg  = 3'd7;
                wb_data = WORD_SIZE'(pc_plus1);
                next_pc = 16'(result_q);
            end
            4'b1100, 4'b1000: next_pc = 16'(result_q);
            4'b0000: begin
                if ((insn_q[11:9] & nzp_q) != 3'b000)
                    next_pc = 16'(result_q);
            end
            4'b0010: is_cmp = 1'b1;
            default: ;
        endcase

        if (in_wb && wb_en)
            nzp_d = nzp_of(wb_data);
        else if (in_wb && is_cmp)
            nzp_d = nzp_of(result_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                rf_q[i] <= '0;
            nzp_q <= 3'b010;
        end else begin
            if (in_wb && wb_en)
                rf_q[wb_reg] <= wb_data;
            nzp_q <= nzp_d;
        end
    end

    // HICONST reads its destination as the first operand so the low byte is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_q   <= '0;
            pc_q     <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                insn_q <= i_insn;
                pc_q   <= i_pc;
                r1_q   <= (i_insn[15:12] == 4'b1101) ? rf_q[i_insn[11:9]] : rf_q[i_insn[8:6]];
                r2_q   <= rf_q[i_insn[2:0]];
            end
            if (state_q == EXEC)
                result_q <= i_alu_result;
        end
    end

    assign o_insn_ready = (state_q == IDLE);
    assign o_alu_insn   = insn_q;
    assign o_alu_pc     = pc_q;
    assign o_alu_r1data = r1_q;
    assign o_alu_r2data = r2_q;
    assign o_done       = in_wb;
    assign o_wb_en      = in_wb && wb_en;
    assign o_wb_reg     = in_wb ? wb_reg : 3'd0;
    assign o_wb_data    = in_wb ? wb_data : '0;
    assign o_next_pc    = in_wb ? next_pc : 16'd0;
    assign o_nzp        = nzp_q;
    assign o_dbg_data   = rf_q[i_dbg_reg];
endmodule

// File: tb/tb_lc4_exec_seq.sv
// Bench for lc4_exec_seq: directed table, random instructions against a register-file model,
// back-to-back valid handling and mid-instruction reset abort.
module tb_lc4_exec_seq;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_insn_valid = 1'b0;
    logic          o_insn_ready;
    logic [15:0]   i_insn = '0, i_pc = '0;
    logic [15:0]   o_alu_insn, o_alu_pc;
    logic [W-1:0]  o_alu_r1data, o_alu_r2data, i_alu_result;
    logic          o_done, o_wb_en;
    logic [2:0]    o_wb_reg, o_nzp;
    logic [W-1:0]  o_wb_data, o_dbg_data;
    logic [15:0]   o_next_pc;
    logic [2:0]    i_dbg_reg = '0;

    int errors = 0;
    int checks = 0;

    lc4_exec_seq #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_insn_valid(i_insn_valid), .o_insn_ready(o_insn_ready),
        .i_insn(i_insn), .i_pc(i_pc),
        .o_alu_insn(o_alu_insn), .o_alu_pc(o_alu_pc),
        .o_alu_r1data(o_alu_r1data), .o_alu_r2data(o_alu_r2data),
        .i_alu_result(i_alu_result), .o_done(o_done),
        .o_wb_en(o_wb_en), .o_wb_reg(o_wb_reg), .o_wb_data(o_wb_data),
        .o_next_pc(o_next_pc), .o_nzp(o_nzp),
        .i_dbg_reg(i_dbg_reg), .o_dbg_data(o_dbg_data)
    );

    always #5 clk = ~clk;

    // Combinational LC4 ALU driven from the registered operands.
    function automatic logic [15:0] lc4_alu(input logic [15:0] insn, input logic [15:0] pc,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [15:0] pc1, r;
        logic signed [15:0] sa, sb;
        logic lt, eq;
        pc1 = pc + 16'd1;
        sa = a;
        sb = b;
        r = '0;
        lt = 1'b0;
        eq = 1'b0;
        case (insn[15:12])
            4'h0: r = pc1 + {{7{insn[8]}}, insn[8:0]};
            4'h1: begin
                if (insn[5]) r = a + {{11{insn[4]}}, insn[4:0]};
                else case (insn[4:3])
                    2'd0: r = a + b;
                    2'd1: r = a * b;
                    2'd2: r = a - b;
                    default: r = (b == 16'd0) ? 16'd0 : a / b;
                endcase
            end
            4'h2: begin
                case (insn[8:7])
                    2'd0: begin lt = sa < sb; eq = a == b; end
                    2'd1: begin lt = a < b; eq = a == b; end
                    2'd2: begin sb = {{9{insn[6]}}, insn[6:0]}; lt = sa < sb; eq = sa == sb; end
                    default: begin lt = a < {9'd0, insn[6:0]}; eq = a == {9'd0, insn[6:0]}; end
                endcase
                r = lt ? 16'hFFFF : (eq ? 16'h0000 : 16'h0001);
            end
            4'h4: r = insn[11] ? ((pc & 16'h8000) | {1'b0, insn[10:0], 4'b0000}) : a;
            4'h5: begin
                if (insn[5]) r = a & {{11{insn[4]}}, insn[4:0]};
                else case (insn[4:3])
                    2'd0: r = a & b;
                    2'd1: r = ~a;
                    2'd2: r = a | b;
                    default: r = a ^ b;
                endcase
            end
            4'h6, 4'h7, 4'hB, 4'hE: r = a + {{10{insn[5]}}, insn[5:0]};
            4'h8: r = a;
            4'h9: r = {{7{insn[8]}}, insn[8:0]};
            4'hA: begin
                case (insn[5:4])
                    2'd0: r = a << insn[3:0];
                    2'd1: r = sa >>> insn[3:0];
                    2'd2: r = a >> insn[3:0];
                    default: r = (b == 16'd0) ? 16'd0 : a % b;
                endcase
            end
            4'hC: r = insn[11] ? pc1 + {{5{insn[10]}}, insn[10:0]} : a;
            4'hD: r = (a & 16'h00FF) | {insn[7:0], 8'h00};
            4'hF: r = 16'h8000 | {8'h00, insn[7:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign i_alu_result = lc4_alu(o_alu_insn, o_alu_pc, o_alu_r1data, o_alu_r2data);

    // Architectural model: register file and condition codes updated by instruction rules.
    logic [15:0] mrf [8];
    logic [2:0]  mnzp;
    logic        m_en;
    logic [2:0]  m_reg, m_nzp;
    logic [15:0] m_data, m_npc, m_r1, m_r2;

    function automatic logic [2:0] nzp_rule(input logic [15:0] v);
        return v[15] ? 3'b100 : ((v == 16'd0) ? 3'b010 : 3'b001);
    endfunction

    task automatic model_exec(input logic [15:0] insn, input logic [15:0] pc);
        logic [3:0] op;
        logic [15:0] res, pc1;
        op = insn[15:12];
        pc1 = pc + 16'd1;
        m_r1 = (op == 4'hD) ? mrf[insn[11:9]] : mrf[insn[8:6]];
        m_r2 = mrf[insn[2:0]];
        res = lc4_alu(insn, pc, m_r1, m_r2);
        m_en = 1'b0; m_reg = insn[11:9]; m_data = res; m_npc = pc1;
        if (op inside {4'h1, 4'h5, 4'h9, 4'hA, 4'hD}) m_en = 1'b1;
        else if (op inside {4'h4, 4'hF}) begin
            m_en = 1'b1; m_reg = 3'd7; m_data = pc1; m_npc = res;
        end
        else if (op inside {4'hC, 4'h8}) m_npc = res;
        else if (op == 4'h0) m_npc = ((insn[11:9] & mnzp) != 3'b000) ? res : pc1;
        else if (op == 4'h2) mnzp = nzp_rule(res);
        if (m_en) begin
            mrf[m_reg] = m_data;
            mnzp = nzp_rule(m_data);
        end
        m_nzp = mnzp;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic read_dbg(input logic [2:0] r, output logic [15:0] d);
        i_dbg_reg = r;
        #1;
        d = o_dbg_data;
    endtask

    // Captured DUT response of one instruction.
    logic        c_ok, c_en, c_done_after, c_ready_after;
    logic [2:0]  c_reg, c_nzp;
    logic [15:0] c_data, c_npc, c_r1, c_r2;
    int          c_lat;

    task automatic run_insn(input logic [15:0] insn, input logic [15:0] pc);
        int n;
        c_ok = 1'b0;
        n = 0;
        while (!o_insn_ready && n < 10) begin @(negedge clk); n++; end
        if (!o_insn_ready) begin chk("ready_timeout", 0, 1); return; end
        i_insn = insn; i_pc = pc; i_insn_valid = 1'b1;
        @(negedge clk);
        i_insn_valid = 1'b0;
        c_r1 = o_alu_r1data; c_r2 = o_alu_r2data;
        n = 0;
        while (!o_done && n < 5) begin @(negedge clk); n++; end
        if (!o_done) begin chk("done_timeout", 0, 1); return; end
        c_lat = n;
        c_en = o_wb_en; c_reg = o_wb_reg; c_data = o_wb_data; c_npc = o_next_pc;
        @(negedge clk);
        c_nzp = o_nzp; c_done_after = o_done; c_ready_after = o_insn_ready;
        c_ok = 1'b1;
    endtask

    typedef struct {
        logic [15:0] insn, pc;
        logic        en;
        logic [2:0]  rd;
        logic [15:0] data, npc;
        logic [2:0]  nzp;
        logic [15:0] r1, r2;
    } vec_t;
    vec_t vecs [7];

    initial begin
        logic [15:0] d, rin, rpc;
        int acc, dn;
        for (int i = 0; i < 8; i++) mrf[i] = 16'd0;
        mnzp = 3'b010;

        vecs[0] = '{16'h93FB, 16'h0000, 1'b1, 3'd1, 16'hFFFB, 16'h0001, 3'b100, 16'h0000, 16'h0000};
        vecs[1] = '{16'h1441, 16'h0001, 1'b1, 3'd2, 16'hFFF6, 16'h0002, 3'b100, 16'hFFFB, 16'hFFFB};
        vecs[2] = '{16'h91FB, 16'h0002, 1'b1, 3'd0, 16'hFFFB, 16'h0003, 3'b100, 16'h0000, 16'h0000};
        vecs[3] = '{16'h2201, 16'h0003, 1'b0, 3'd0, 16'h0000, 16'h0004, 3'b010, 16'hFFFB, 16'hFFFB};
        vecs[4] = '{16'h0404, 16'h0010, 1'b0, 3'd0, 16'h0000, 16'h0015, 3'b010, 16'hFFFB, 16'h0000};
        vecs[5] = '{16'h0204, 16'h0010, 1'b0, 3'd0, 16'h0000, 16'h0011, 3'b010, 16'hFFFB, 16'h0000};
        vecs[6] = '{16'h4805, 16'hFFFF, 1'b1, 3'd7, 16'h0000, 16'h8050, 3'b010, 16'hFFFB, 16'h0000};

        // Reset state, observed while reset is still held.
        repeat (2) @(negedge clk);
        chk("rst_ready", o_insn_ready, 1);
        chk("rst_done", o_done, 0);
        chk("rst_nzp", o_nzp, 3'b010);
        chk("rst_alu_insn", o_alu_insn, 0);
        chk("rst_next_pc", o_next_pc, 0);
        for (int i = 0; i < 8; i++) begin
            read_dbg(3'(i), d);
            chk($sformatf("rst_rf%0d", i), d, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        for (int v = 0; v < 7; v++) begin
            model_exec(vecs[v].insn, vecs[v].pc);
            run_insn(vecs[v].insn, vecs[v].pc);
            if (c_ok) begin
                chk($sformatf("v%0d_r1", v), c_r1, vecs[v].r1);
                chk($sformatf("v%0d_r2", v), c_r2, vecs[v].r2);
                chk($sformatf("v%0d_latency", v), c_lat, 1);
                chk($sformatf("v%0d_wb_en", v), c_en, vecs[v].en);
                chk($sformatf("v%0d_next_pc", v), c_npc, vecs[v].npc);
                chk($sformatf("v%0d_nzp", v), c_nzp, vecs[v].nzp);
                chk($sformatf("v%0d_done_pulse", v), c_done_after, 0);
                chk($sformatf("v%0d_ready_again", v), c_ready_after, 1);
                if (vecs[v].en) begin
                    chk($sformatf("v%0d_wb_reg", v), c_reg, vecs[v].rd);
                    chk($sformatf("v%0d_wb_data", v), c_data, vecs[v].data);
                    read_dbg(vecs[v].rd, d);
                    chk($sformatf("v%0d_rf", v), d, vecs[v].data);
                end
            end
        end

        // Random instructions against the model.
        for (int k = 0; k < 40; k++) begin
            rin = 16'($urandom);
            rpc = 16'($urandom);
            model_exec(rin, rpc);
            run_insn(rin, rpc);
            if (c_ok) begin
                chk($sformatf("rnd%0d_r1 insn=%h", k, rin), c_r1, m_r1);
                chk($sformatf("rnd%0d_r2 insn=%h", k, rin), c_r2, m_r2);
                chk($sformatf("rnd%0d_wb_en insn=%h", k, rin), c_en, m_en);
                chk($sformatf("rnd%0d_next_pc insn=%h", k, rin), c_npc, m_npc);
                chk($sformatf("rnd%0d_nzp insn=%h", k, rin), c_nzp, m_nzp);
                if (m_en) begin
                    chk($sformatf("rnd%0d_wb_reg insn=%h", k, rin), c_reg, m_reg);
                    chk($sformatf("rnd%0d_wb_data insn=%h", k, rin), c_data, m_data);
                    read_dbg(m_reg, d);
                    chk($sformatf("rnd%0d_rf insn=%h", k, rin), d, m_data);
                end
            end
        end

        // Valid held high: ADD R6,R6,#1 must run once per three cycles.
        acc = 0;
        dn = 0;
        i_insn = 16'h1DA1; i_pc = 16'h0100; i_insn_valid = 1'b1;
        for (int s = 0; s < 30; s++) begin
            if (o_insn_ready) acc++;
            if (o_done) dn++;
            @(negedge clk);
        end
        i_insn_valid = 1'b0;
        for (int s = 0; s < 10; s++) model_exec(16'h1DA1, 16'h0100);
        chk("stream_accepts", acc, 10);
        chk("stream_dones", dn, 10);
        read_dbg(3'd6, d);
        chk("stream_r6", d, mrf[6]);
        chk("stream_nzp", o_nzp, mnzp);

        // Reset mid-EXEC of ADD R3,R1,R1 aborts it.
        @(negedge clk);
        chk("abort_ready_pre", o_insn_ready, 1);
        i_insn = 16'h1641; i_pc = 16'h0200; i_insn_valid = 1'b1;
        @(negedge clk);
        i_insn_valid = 1'b0;
        chk("abort_in_exec", o_insn_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_async_ready", o_insn_ready, 1);
        chk("abort_async_done", o_done, 0);
        chk("abort_async_alu_r1", o_alu_r1data, 0);
        chk("abort_async_wb_en", o_wb_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_after", o_insn_ready, 1);
        dn = 0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            if (o_done) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_nzp", o_nzp, 3'b010);
        for (int i = 0; i < 8; i++) begin
            read_dbg(3'(i), d);
            chk($sformatf("abort_rf%0d", i), d, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
